// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding, default vectors and the alignment helper
// for the PC sequencer.
package pc_seq_pkg;
   typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, STALL = 2'd2, HALT = 2'd3} state_t;
   localparam int          XLEN_DEF         = 32;
   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
   localparam int          INCR_DEF         = 4;
   function automatic logic is_aligned(input logic [1:0] lsb);
      return lsb == 2'b00;
   endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-fetch request bus between the PC sequencer
// (master) and instruction memory (slave).
interface pc_sequencer_if #(parameter int XLEN = 32) ();
   logic            fetch_valid;
   logic            fetch_ready;
   logic [XLEN-1:0] address;
   modport master (output fetch_valid, output address, input fetch_ready);
   modport slave  (input fetch_valid, input address, output fetch_ready);
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: picks the next PC (redirect > pending > sequential) and
// substitutes the trap vector for misaligned redirect targets.
module pc_next_sel
   import pc_seq_pkg::*;
#(
   parameter int              XLEN        = XLEN_DEF,
   parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(TRAP_VECTOR_DEF),
   parameter int              INCR        = INCR_DEF
) (
   input  logic [XLEN-1:0] i_addr,
   input  logic            i_redir_valid,
   input  logic [XLEN-1:0] i_redir_target,
   input  logic            i_load,
   input  logic            i_pend_valid,
   input  logic [XLEN-1:0] i_pend_target,
   input  logic            i_accept,
   output logic [XLEN-1:0] o_next,
   output logic [XLEN-1:0] o_target,
   output logic            o_misalign
);
   logic w_aligned;
   always_comb begin
      w_aligned  = is_aligned(i_redir_target[1:0]);
      o_target   = w_aligned ? i_redir_target : TRAP_VECTOR;
      o_misalign = i_redir_valid && !w_aligned;
      o_next     = (i_redir_valid && i_load) ? o_target :
                   !i_accept                 ? i_addr :
                   i_pend_valid              ? i_pend_target :
                                               i_addr + XLEN'(INCR);
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, issues fetch requests over valid/ready and
// applies redirects, stalls and halt/resume.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              XLEN         = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
   parameter int              INCR         = INCR_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_stall,
   input  logic              i_halt,
   input  logic              i_resume,
   input  logic              i_redirect_valid,
   input  logic [XLEN-1:0]   i_redirect_target,
   pc_sequencer_if.master    fetch_if,
   output logic              o_misalign_err,
   output logic [31:0]       o_fetch_count,
   output state_t            o_state
);
   state_t          r_state, w_state_nx;
   logic [XLEN-1:0] r_addr, r_pend_target, w_next, w_target, w_pend_target_nx;
   logic            r_pend_valid, r_misalign, w_pend_valid_nx;
   logic [31:0]     r_count;
   logic            w_accept, w_hold, w_redir, w_misalign;

   // Redirects are meaningless before the first request exists.
   assign w_redir  = i_redirect_valid && (r_state != BOOT);
   assign w_accept = (r_state == FETCH) && fetch_if.fetch_ready;
   assign w_hold   = (r_state == FETCH) && !fetch_if.fetch_ready;

   pc_next_sel #(.XLEN(XLEN), .TRAP_VECTOR(TRAP_VECTOR), .INCR(INCR)) u_next_sel (
      .i_addr         (r_addr),
      .i_redir_valid  (w_redir),
      .i_redir_target (i_redirect_target),
      .i_load         (!w_hold),
      .i_pend_valid   (r_pend_valid),
      .i_pend_target  (r_pend_target),
      .i_accept       (w_accept),
      .o_next         (w_next),
      .o_target       (w_target),
      .o_misalign     (w_misalign)
   );

   always_comb begin
      w_state_nx       = r_state;
      w_pend_valid_nx  = w_accept ? 1'b0 : (r_pend_valid || (w_hold && w_redir));
      w_pend_target_nx = (w_hold && w_redir) ? w_target : r_pend_target;
      case (r_state)
         BOOT:    w_state_nx = FETCH;
         FETCH:   w_state_nx = !w_accept ? FETCH : i_halt ? HALT : i_stall ? STALL : FETCH;
         STALL:   w_state_nx = i_halt ? HALT : i_stall ? STALL : FETCH;
         default: w_state_nx = i_resume ? FETCH : HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= BOOT;
         r_addr        <= RESET_VECTOR;
         r_pend_valid  <= 1'b0;
         r_pend_target <= '0;
         r_misalign    <= 1'b0;
         r_count       <= '0;
      end else begin
         r_state       <= w_state_nx;
         r_addr        <= w_next;
         r_pend_valid  <= w_pend_valid_nx;
         r_pend_target <= w_pend_target_nx;
         r_misalign    <= w_misalign;
         r_count       <= r_count + {31'b0, w_accept};
      end
   end

   assign fetch_if.fetch_valid = (r_state == FETCH);
   assign fetch_if.address     = r_addr;
   assign o_misalign_err       = r_misalign;
   assign o_fetch_count        = r_count;
   assign o_state              = r_state;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan scenarios followed by random stimulus,
// all checked against a cycle-level reference model of the sequencing rules.
module tb_pc_sequencer;
   import pc_seq_pkg::*;
   logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, halt = 1'b0, resume = 1'b0, rv = 1'b0;
   logic [31:0] rt = '0;
   logic        misalign;
   logic [31:0] count, saved;
   state_t      st;
   int          errors = 0, checks = 0;
   int          m_state = 0;
   logic [31:0] m_addr = '0, m_pt = '0, m_cnt = '0;
   logic        m_pv = 1'b0, m_err = 1'b0;

   pc_sequencer_if bus ();
   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk               (clk),
      .rst               (rst),
      .i_stall           (stall),
      .i_halt            (halt),
      .i_resume          (resume),
      .i_redirect_valid  (rv),
      .i_redirect_target (rt),
      .fetch_if          (bus.master),
      .o_misalign_err    (misalign),
      .o_fetch_count     (count),
      .o_state           (st)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [31:0] san(input logic [31:0] t);
      return (t[1:0] == 2'b00) ? t : 32'h0000_0100;
   endfunction

   // Reference: 0=boot, 1=fetching, 2=stalled, 3=halted.
   task automatic model_step();
      logic mis;
      mis = rv && (rt[1:0] != 2'b00);
      if (rst) begin
         m_state = 0; m_addr = 32'h0; m_pv = 0; m_pt = 0; m_err = 0; m_cnt = 0;
         return;
      end
      m_err = 0;
      if (m_state == 0) begin
         m_state = 1;
      end else if (m_state == 1) begin
         m_err = mis;
         if (bus.fetch_ready) begin
            m_cnt = m_cnt + 1;
            m_addr = rv ? san(rt) : m_pv ? m_pt : m_addr + 4;
            m_pv = 0;
            m_state = halt ? 3 : stall ? 2 : 1;
         end else if (rv) begin
            m_pv = 1;
            m_pt = san(rt);
         end
      end else begin
         m_err = mis;
         if (rv) m_addr = san(rt);
         if (m_state == 2) m_state = halt ? 3 : stall ? 2 : 1;
         else m_state = resume ? 1 : 3;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, m_state == 1});
      check("address", bus.address, m_addr);
      check("state", {30'b0, st}, m_state);
      check("fetch_count", count, m_cnt);
      check("misalign_err", {31'b0, misalign}, {31'b0, m_err});
   endtask

   initial begin
      bus.fetch_ready = 1'b1;
      cycle(); cycle();
      check("reset_state", {30'b0, st}, 32'd0);
      rst = 0;
      cycle();
      check("first_req_valid", {31'b0, bus.fetch_valid}, 32'd1);
      check("first_req_addr", bus.address, 32'h0);
      cycle(); cycle();
      bus.fetch_ready = 0;
      cycle();
      rv = 1; rt = 32'h40;
      cycle();
      rv = 0;
      cycle();
      check("hold_addr", bus.address, 32'h8);
      check("hold_valid", {31'b0, bus.fetch_valid}, 32'd1);
      bus.fetch_ready = 1;
      cycle();
      check("pending_applied", bus.address, 32'h40);
      cycle();
      check("after_pending", bus.address, 32'h44);
      check("count_after_4", count, 32'd4);
      rv = 1; rt = 32'h42;
      cycle();
      check("trap_addr", bus.address, 32'h100);
      check("misalign_pulse", {31'b0, misalign}, 32'd1);
      rv = 0;
      cycle();
      check("misalign_drop", {31'b0, misalign}, 32'd0);
      rv = 1; rt = 32'h10;
      cycle();
      rv = 0; stall = 1;
      cycle();
      check("stall_state", {30'b0, st}, 32'd2);
      check("stall_valid", {31'b0, bus.fetch_valid}, 32'd0);
      rv = 1; rt = 32'h80;
      cycle();
      rv = 0; stall = 0;
      cycle();
      check("post_stall_addr", bus.address, 32'h80);
      rv = 1; rt = 32'h20;
      cycle();
      rv = 0; halt = 1;
      cycle();
      halt = 0; saved = count;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("halt_valid", {31'b0, bus.fetch_valid}, 32'd0);
         check("halt_count", count, saved);
      end
      resume = 1;
      cycle();
      resume = 0;
      check("resume_addr", bus.address, 32'h24);
      check("resume_valid", {31'b0, bus.fetch_valid}, 32'd1);
      rv = 1; rt = 32'h30;
      cycle();
      rv = 0; bus.fetch_ready = 0;
      cycle();
      rv = 1; rt = 32'h200;
      cycle();
      rv = 0; rst = 1;
      cycle();
      rst = 0; bus.fetch_ready = 1;
      cycle();
      check("rst_first_addr", bus.address, 32'h0);
      check("rst_count", count, 32'd0);
      cycle();
      check("pending_dropped", bus.address, 32'h4);
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(99) == 0);
         bus.fetch_ready = ($urandom_range(9) < 7);
         stall = ($urandom_range(6) == 0);
         halt = ($urandom_range(19) == 0);
         resume = ($urandom_range(3) == 0);
         rv = ($urandom_range(5) == 0);
         rt = $urandom;
         if ($urandom_range(2) != 0) rt[1:0] = 2'b00;
         cycle();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
